rv_muldiv_unit: RTL
===================

Name: rv_muldiv_unit

Overview:
Iterative M-extension multiply/divide execution unit for the IDE stage, parametrised in datapath width and radix. It replaces the fixed single-width multi-cycle MUL path. It adds all eight RV32M-style operations, a valid/ready handshake on both sides, a destination tag passthrough, flush abort and a stall output. It sits beside the ALU: the decoder issues to it, and its result goes to register writeback.

Parameters:
XLEN, 16, operand/result width; must be even and >= 8.
UNROLL, 1, iteration steps per clock (1, 2 or 4); XLEN must be divisible by UNROLL.
TAG_W, 5, width of the destination-register tag carried with each operation.

Ports:
clk  in  1  clock; all state changes on the rising edge.
rst  in  1  asynchronous, active-high reset.
i_valid  in  1  issue request.
o_ready  out  1  unit can accept an operation; high only in IDLE.
i_op  in  3  funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
i_rs1  in  XLEN  operand A (dividend).
i_rs2  in  XLEN  operand B (divisor).
i_tag  in  TAG_W  destination tag.
i_flush  in  1  abort any in-flight operation.
o_valid  out  1  result available.
i_ready  in  1  consumer accepts result.
o_result  out  XLEN  result.
o_tag  out  TAG_W  tag of the result.
o_stall  out  1  high when not IDLE; drives the pipeline stall.

Behaviour:
- States: IDLE, BUSY, DONE. On reset (async): state IDLE, o_ready=1, o_valid=0, o_stall=0, o_result=0, o_tag=0, iteration counter 0.
- Accept: on an edge with i_valid & o_ready & !i_flush, latch the op, tag and operand magnitudes, then go to BUSY. Latch the sign bits: rs1 is signed for MULH, MULHSU, DIV and REM; rs2 is signed for MULH, DIV and REM.
- BUSY: performs UNROLL steps per edge for N = XLEN/UNROLL edges.
  - Multiply: shift-add into a 2*XLEN product.
  - Divide: restoring shift-subtract producing quotient and remainder.
  - After the Nth BUSY edge, the state is DONE. Latency is N+1 edges from accept to o_valid high; for XLEN=16, UNROLL=1 this is 17.
- Final sign fix-up happens on the last BUSY edge:
  - Product is negated if the operand signs differ.
  - Quotient is negated if the dividend and divisor signs differ.
  - Remainder takes the sign of the dividend.
- Result selection:
  - MUL: low XLEN of the product. MULH, MULHSU, MULHU: high XLEN.
  - DIV, DIVU: quotient. REM, REMU: remainder.
- Divide by zero:
  - Quotient is all ones (DIV and DIVU).
  - Remainder equals rs1 unmodified.
  - Normal latency unless ES below applies.
- Signed overflow (rs1 = 1<<(XLEN-1), rs2 = all ones, DIV/REM): quotient = rs1, remainder = 0.
- DONE: o_valid=1, with o_result and o_tag stable until an edge where i_ready=1; then the state is IDLE. There is no accept in the same edge as retire; o_ready rises the cycle after retire.
- o_stall = (state != IDLE). It is combinational from state.
- Flush: i_flush=1 on any edge forces IDLE and o_valid=0, discarding the result. Flush has priority over accept and over retire.
- Reset mid-operation: immediate return to IDLE, with no result produced.
- An i_op or operand change while BUSY has no effect because the inputs are latched.

Optional Feature:
MULDIV_EARLY_OUT_EN: when defined, the following cases skip BUSY and enter DONE on the accept edge, giving o_valid one cycle after accept:
- divide by zero;
- signed overflow;
- multiply with either operand zero;
- divide with rs1 = 0.
Results are identical to the iterative path. When not defined, every operation takes N+1 cycles.

Test Plan:
1. XLEN=16, UNROLL=1: MUL 0x0003 x 0x0005 (tag 3) -> o_valid 17 edges after accept, o_result=0x000F, o_tag=3, o_stall high for 17 cycles.
2. MULH 0xFFFE x 0x0003 -> 0xFFFF. MULHU 0xFFFE x 0x0003 -> 0x0002. MULHSU 0xFFFE x 0x0003 -> 0xFFFF.
3. DIVU 100/7 -> 0x000E. REMU 100/7 -> 0x0002. REM 0xFFF9/0x0002 -> 0xFFFF. DIV 0x8000/0xFFFF -> 0x8000. REM 0x8000/0xFFFF -> 0x0000.
4. DIV 0x1234/0 -> 0xFFFF; REMU 0x1234/0 -> 0x1234. Latency 17 without the macro and 1 with MULDIV_EARLY_OUT_EN.
5. Backpressure: hold i_ready=0 for 3 cycles in DONE -> o_valid, o_result and o_tag are held unchanged, o_ready=0. Raise i_ready -> IDLE next edge and o_ready=1. A new issue in that cycle is accepted the following edge.
6. Flush at BUSY edge 5, then rst pulse mid-op in a second run -> IDLE with no o_valid pulse. The next MUL 7x6 returns 0x002A. UNROLL=4 rerun of scenario 1 -> latency 5 edges.

Source files
------------

// File: rtl/rv_muldiv_unit_if.sv
`default_nettype none
// ============================================================================
// Module      : rv_muldiv_unit_if
// Description : Issue/result handshake bundle for the iterative M-extension
//               multiply/divide unit. The master drives operations and
//               consumes results; the slave is the execution unit.
// Revision    : 1.0 - initial release
// ============================================================================
interface rv_muldiv_unit_if #(
   parameter int XLEN  = 16,
   parameter int TAG_W = 5
);
   logic             i_valid;
   logic             o_ready;
   logic [2:0]       i_op;
   logic [XLEN-1:0]  i_rs1;
   logic [XLEN-1:0]  i_rs2;
   logic [TAG_W-1:0] i_tag;
   logic             i_flush;
   logic             o_valid;
   logic             i_ready;
   logic [XLEN-1:0]  o_result;
   logic [TAG_W-1:0] o_tag;
   logic             o_stall;

   modport master (
      output i_valid, i_op, i_rs1, i_rs2, i_tag, i_flush, i_ready,
      input  o_ready, o_valid, o_result, o_tag, o_stall
   );

   modport slave (
      input  i_valid, i_op, i_rs1, i_rs2, i_tag, i_flush, i_ready,
      output o_ready, o_valid, o_result, o_tag, o_stall
   );
endinterface
`default_nettype wire

// File: rtl/rv_muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module      : rv_muldiv_unit
// Description : Iterative RV32M-style multiply/divide unit. Shift-add multiply
//               and restoring divide share one {hi,lo} datapath, UNROLL steps
//               per clock, XLEN/UNROLL busy cycles. Sign fix-up and result
//               selection happen on the last busy edge.
//               Optional macro MULDIV_EARLY_OUT_EN: trivial cases (divide by
//               zero, signed overflow, zero multiply operand, zero dividend)
//               go straight to DONE on the accept edge.
// Revision    : 1.0 - initial release
// ============================================================================
module rv_muldiv_unit #(
   parameter int XLEN   = 16,
   parameter int UNROLL = 1,
   parameter int TAG_W  = 5
) (
   input  wire             clk,
   input  wire             rst,
   rv_muldiv_unit_if.slave bus
);

   localparam int               N     = XLEN / UNROLL;
   localparam int               CNT_W = $clog2(N);
   localparam logic [CNT_W-1:0] c_LAST = CNT_W'(N - 1);
   localparam logic [XLEN-1:0]  c_MIN  = {1'b1, {(XLEN-1){1'b0}}};

   localparam logic [2:0] c_OP_MUL    = 3'b000;
   localparam logic [2:0] c_OP_MULH   = 3'b001;
   localparam logic [2:0] c_OP_MULHSU = 3'b010;
   localparam logic [2:0] c_OP_MULHU  = 3'b011;
   localparam logic [2:0] c_OP_DIV    = 3'b100;
   localparam logic [2:0] c_OP_DIVU   = 3'b101;
   localparam logic [2:0] c_OP_REM    = 3'b110;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_BUSY = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t             state_q, state_d;
   logic [2:0]         op_q, op_d;
   logic [TAG_W-1:0]   tag_q, tag_d;
   logic               sa_q, sa_d;
   logic               sb_q, sb_d;
   logic [XLEN-1:0]    a_q, a_d;
   logic [XLEN-1:0]    b_q, b_d;
   logic [XLEN-1:0]    hi_q, hi_d;
   logic [XLEN-1:0]    lo_q, lo_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [XLEN-1:0]    result_q, result_d;

   logic               w_rs1_sgn, w_rs2_sgn;
   logic [XLEN-1:0]    w_rs1_mag, w_rs2_mag;
   logic [XLEN-1:0]    w_step_hi, w_step_lo;
   logic [XLEN:0]      w_t;
   logic [XLEN-1:0]    w_add;
   logic [2*XLEN-1:0]  w_prod_mag, w_prod;
   logic [XLEN-1:0]    w_quo, w_rem, w_final;
   logic               w_early;
   logic [XLEN-1:0]    w_early_res;

   // Operand signs: rs1 signed for MULH/MULHSU/DIV/REM, rs2 for MULH/DIV/REM.
   assign w_rs1_sgn = bus.i_rs1[XLEN-1] &
                      ((bus.i_op == c_OP_MULH) || (bus.i_op == c_OP_MULHSU) ||
                       (bus.i_op == c_OP_DIV)  || (bus.i_op == c_OP_REM));
   assign w_rs2_sgn = bus.i_rs2[XLEN-1] &
                      ((bus.i_op == c_OP_MULH) || (bus.i_op == c_OP_DIV) ||
                       (bus.i_op == c_OP_REM));
   assign w_rs1_mag = w_rs1_sgn ? -bus.i_rs1 : bus.i_rs1;
   assign w_rs2_mag = w_rs2_sgn ? -bus.i_rs2 : bus.i_rs2;

   // UNROLL iteration steps: restoring divide (lo = quotient) or shift-add multiply.
   always_comb begin
      w_step_hi = hi_q;
      w_step_lo = lo_q;
      w_t       = '0;
      w_add     = '0;
      for (int i = 0; i < UNROLL; i++) begin
         if (op_q[2]) begin
            w_t       = {w_step_hi, w_step_lo[XLEN-1]};
            w_step_lo = {w_step_lo[XLEN-2:0], 1'b0};
            if (w_t >= {1'b0, b_q}) begin
               w_t          = w_t - {1'b0, b_q};
               w_step_lo[0] = 1'b1;
            end
            w_step_hi = w_t[XLEN-1:0];
         end else begin
            w_add     = w_step_lo[0] ? a_q : '0;
            w_t       = {1'b0, w_step_hi} + {1'b0, w_add};
            w_step_lo = {w_t[0], w_step_lo[XLEN-1:1]};
            w_step_hi = w_t[XLEN:1];
         end
      end
   end

   // Sign fix-up; a zero divisor leaves the remainder equal to rs1 naturally.
   assign w_prod_mag = {w_step_hi, w_step_lo};
   assign w_prod     = (sa_q ^ sb_q) ? -w_prod_mag : w_prod_mag;
   assign w_quo      = (b_q == '0) ? '1 : ((sa_q ^ sb_q) ? -w_step_lo : w_step_lo);
   assign w_rem      = sa_q ? -w_step_hi : w_step_hi;

   // Result selection by funct3.
   always_comb begin
      w_final = w_rem;
      case (op_q)
         c_OP_MUL:                          w_final = w_prod[XLEN-1:0];
         c_OP_MULH, c_OP_MULHSU, c_OP_MULHU: w_final = w_prod[2*XLEN-1:XLEN];
         c_OP_DIV, c_OP_DIVU:               w_final = w_quo;
         default:                           w_final = w_rem;
      endcase
   end

`ifdef MULDIV_EARLY_OUT_EN
   // Detect operations whose result is known at issue time.
   always_comb begin
      w_early     = 1'b0;
      w_early_res = '0;
      if (bus.i_op[2]) begin
         if (bus.i_rs2 == '0) begin
            w_early     = 1'b1;
            w_early_res = bus.i_op[1] ? bus.i_rs1 : '1;
         end else if (!bus.i_op[0] && (bus.i_rs1 == c_MIN) && (bus.i_rs2 == '1)) begin
            w_early     = 1'b1;
            w_early_res = bus.i_op[1] ? '0 : c_MIN;
         end else if (bus.i_rs1 == '0) begin
            w_early = 1'b1;
         end
      end else if ((bus.i_rs1 == '0) || (bus.i_rs2 == '0)) begin
         w_early = 1'b1;
      end
   end
`else
   assign w_early     = 1'b0;
   assign w_early_res = '0;
`endif

   // Next-state and datapath load/iterate; flush overrides everything.
   always_comb begin
      state_d  = state_q;
      op_d     = op_q;
      tag_d    = tag_q;
      sa_d     = sa_q;
      sb_d     = sb_q;
      a_d      = a_q;
      b_d      = b_q;
      hi_d     = hi_q;
      lo_d     = lo_q;
      cnt_d    = cnt_q;
      result_d = result_q;
      case (state_q)
         S_IDLE: begin
            if (bus.i_valid) begin
               op_d  = bus.i_op;
               tag_d = bus.i_tag;
               sa_d  = w_rs1_sgn;
               sb_d  = w_rs2_sgn;
               a_d   = w_rs1_mag;
               b_d   = w_rs2_mag;
               hi_d  = '0;
               lo_d  = bus.i_op[2] ? w_rs1_mag : w_rs2_mag;
               cnt_d = '0;
               if (w_early) begin
                  result_d = w_early_res;
                  state_d  = S_DONE;
               end else begin
                  state_d  = S_BUSY;
               end
            end
         end
         S_BUSY: begin
            hi_d  = w_step_hi;
            lo_d  = w_step_lo;
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == c_LAST) begin
               result_d = w_final;
               cnt_d    = '0;
               state_d  = S_DONE;
            end
         end
         S_DONE: begin
            if (bus.i_ready) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
      if (bus.i_flush) begin
         state_d = S_IDLE;
         cnt_d   = '0;
      end
   end

   // State and datapath registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= S_IDLE;
         op_q     <= '0;
         tag_q    <= '0;
         sa_q     <= 1'b0;
         sb_q     <= 1'b0;
         a_q      <= '0;
         b_q      <= '0;
         hi_q     <= '0;
         lo_q     <= '0;
         cnt_q    <= '0;
         result_q <= '0;
      end else begin
         state_q  <= state_d;
         op_q     <= op_d;
         tag_q    <= tag_d;
         sa_q     <= sa_d;
         sb_q     <= sb_d;
         a_q      <= a_d;
         b_q      <= b_d;
         hi_q     <= hi_d;
         lo_q     <= lo_d;
         cnt_q    <= cnt_d;
         result_q <= result_d;
      end
   end

   assign bus.o_ready  = (state_q == S_IDLE);
   assign bus.o_valid  = (state_q == S_DONE);
   assign bus.o_stall  = (state_q != S_IDLE);
   assign bus.o_result = result_q;
   assign bus.o_tag    = tag_q;

endmodule
`default_nettype wire
